// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared types and constants for the Wishbone round-robin arbiter
package wb_arb_pkg;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Width of a counter that must be able to hold the value cyc itself.
    function automatic int cnt_width(input int cyc);
        return $clog2(cyc + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT_CYC);

    // Arbiter states, kept as plain constants so older tooling can read dumps.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_OWN     = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - bundle of master-side, slave-side and status signals of the arbiter
interface wb_bus_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
);
    logic                boot_hold;
    logic [NUM_M-1:0]    m_cyc;
    logic [NUM_M-1:0]    m_stb;
    logic [NUM_M-1:0]    m_we;
    logic [NUM_M*AW-1:0] m_adr;
    logic [NUM_M*DW-1:0] m_dat;
    logic [NUM_M-1:0]    m_ack;
    logic [NUM_M-1:0]    m_err;
    logic                s_cyc;
    logic                s_stb;
    logic                s_we;
    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_dat;
    logic                s_ack;
    logic [NUM_M-1:0]    grant;
    logic                timeout_flag;

    // Arbiter view: it is the bus master towards the shared slave port.
    modport master (
        input  boot_hold, m_cyc, m_stb, m_we, m_adr, m_dat, s_ack,
        output m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat, grant, timeout_flag
    );

    // Environment view: requesters plus the shared slave.
    modport slave (
        output boot_hold, m_cyc, m_stb, m_we, m_adr, m_dat, s_ack,
        input  m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat, grant, timeout_flag
    );
endinterface

// File: rtl/wb_bus_arbiter_rr_pick.sv
// rtl/wb_bus_arbiter_rr_pick.sv - combinational round-robin picker (first eligible after last index)
module rr_pick #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          valid
);
    // Scan N positions starting just after last_idx, wrapping; first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_idx) + k) % N;
            if (!valid && eligible[idx]) begin
                valid    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin Wishbone arbiter with boot exclusivity; optional WB_ARB_TIMEOUT_EN stall abort
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    wb_bus_arbiter_if.master  bus
);
    localparam int IW = $clog2(NUM_M);

    state_t           state;
    logic [NUM_M-1:0] grant_q;
    logic [IW-1:0]    last_q;
    logic [NUM_M-1:0] eligible;
    logic [NUM_M-1:0] pick_win;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             in_own;
    logic             own_cyc;
    logic             own_stb;
    logic             abort;
    logic             leave;

    // While loading is in progress only the boot loader may compete.
    assign eligible = bus.boot_hold ? (bus.m_cyc & NUM_M'(1)) : bus.m_cyc;

    rr_pick #(.N(NUM_M)) u_pick (
        .eligible (eligible),
        .last_idx (last_q),
        .win      (pick_win),
        .win_idx  (pick_idx),
        .valid    (pick_valid)
    );

    // last_q doubles as the owner index while in OWN.
    assign in_own  = (state == ST_OWN);
    assign own_cyc = bus.m_cyc[last_q];
    assign own_stb = bus.m_stb[last_q];
    assign leave   = in_own && (!own_cyc || abort);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;

    assign abort            = in_own && (cnt_q == CNT_W'(TIMEOUT_CYC));
    assign bus.m_err        = abort ? grant_q : '0;
    assign bus.timeout_flag = flag_q;

    // Count consecutive stalled strobe cycles of the current owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (in_own && !leave && own_stb && !bus.s_ack)
            cnt_q <= cnt_q + 1'b1;
        else
            cnt_q <= '0;
    end

    // Sticky record that at least one transfer was aborted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flag_q <= 1'b0;
        else if (abort)
            flag_q <= 1'b1;
    end
`else
    assign abort            = 1'b0;
    assign bus.m_err        = '0;
    assign bus.timeout_flag = 1'b0;
`endif

    // Ownership FSM: arbitrate in IDLE, hold while owner keeps cyc, one dead cycle after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_M - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state   <= ST_OWN;
                        grant_q <= pick_win;
                        last_q  <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (leave) begin
                        state   <= ST_RELEASE;
                        grant_q <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Route the owner onto the slave port; acks only reach the owner and only in OWN.
    always_comb begin
        bus.grant = grant_q;
        bus.s_cyc = in_own && own_cyc && !abort;
        bus.s_stb = in_own && own_stb && !abort;
        bus.s_we  = in_own && bus.m_we[last_q];
        bus.s_adr = in_own ? bus.m_adr[int'(last_q)*AW +: AW] : '0;
        bus.s_dat = in_own ? bus.m_dat[int'(last_q)*DW +: DW] : '0;
        bus.m_ack = (in_own && bus.s_ack && !abort) ? grant_q : '0;
    end

endmodule
